// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller for a 5-stage in-order pipeline.
// Latency: stall/bubble are combinational; forwarda/forwardb are registered (valid during EX).
// Backpressure: stall holds PC and IF/ID for one cycle per load-use hit; flush overrides stall.
module fwd_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        flush,
    output logic [1:0]  forwarda,
    output logic [1:0]  forwardb,
    output logic        stall,
    output logic        bubble,
    output logic [15:0] stall_cnt
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    // Shadow copies of the downstream pipeline stages.
    logic       ex_valid, ex_regwrite, ex_memread;
    logic [4:0] ex_rs, ex_rt, ex_rd;
    logic       mem_valid, mem_regwrite;
    logic [4:0] mem_rd;
    logic       wb_valid, wb_regwrite;
    logic [4:0] wb_rd;

    logic       ex_src, mem_src, load_hit;
    logic       ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    logic [1:0] fwd_a_nxt, fwd_b_nxt;

    // Hazard detection and next forward selects for the instruction about to enter EX.
    always_comb begin
        ex_src    = ex_valid & ex_regwrite & (ex_rd != 5'd0);
        mem_src   = mem_valid & mem_regwrite & (mem_rd != 5'd0);

        load_hit  = ex_valid & ex_memread & (ex_rd != 5'd0) &
                    ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
        stall     = id_valid & ~flush & load_hit;
        bubble    = stall | flush;

        ex_hit_a  = id_use_rs & ex_src  & (ex_rd  == id_rs);
        ex_hit_b  = id_use_rt & ex_src  & (ex_rd  == id_rt);
        mem_hit_a = id_use_rs & mem_src & (mem_rd == id_rs);
        mem_hit_b = id_use_rt & mem_src & (mem_rd == id_rt);

        // A load in EX cannot supply its data yet; it falls through to the MEM check.
        // WB is never a source: the register file writes before it is read.
        fwd_a_nxt = SEL_RF;
        fwd_b_nxt = SEL_RF;
        if (!bubble) begin
            if (ex_hit_a && !ex_memread) fwd_a_nxt = SEL_MEM;
            else if (mem_hit_a)          fwd_a_nxt = SEL_WB;
            if (ex_hit_b && !ex_memread) fwd_b_nxt = SEL_MEM;
            else if (mem_hit_b)          fwd_b_nxt = SEL_WB;
        end
    end

    // Advance shadow stages, register forward selects and count load-use stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            ex_rs        <= 5'd0;
            ex_rt        <= 5'd0;
            ex_rd        <= 5'd0;
            mem_valid    <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_rd       <= 5'd0;
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_rd        <= 5'd0;
            forwarda     <= SEL_RF;
            forwardb     <= SEL_RF;
            stall_cnt    <= 16'd0;
        end else begin
            wb_valid     <= mem_valid;
            wb_regwrite  <= mem_regwrite;
            wb_rd        <= mem_rd;
            mem_valid    <= ex_valid;
            mem_regwrite <= ex_regwrite;
            mem_rd       <= ex_rd;
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;
            ex_rd        <= id_rd;
            ex_valid     <= id_valid    & ~bubble;
            ex_regwrite  <= id_regwrite & ~bubble;
            ex_memread   <= id_memread  & ~bubble;
            forwarda     <= fwd_a_nxt;
            forwardb     <= fwd_b_nxt;
            if (stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

`ifndef SYNTHESIS
    // A registered select must name a live producer of the EX operand one or two stages ahead.
    always_comb begin
        if (!rst) begin
            assert (forwarda != 2'b11);
            assert (forwardb != 2'b11);
            if (forwarda == SEL_MEM) assert (mem_valid && mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rs);
            if (forwardb == SEL_MEM) assert (mem_valid && mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rt);
            if (forwarda == SEL_WB)  assert (wb_valid && wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_rs);
            if (forwardb == SEL_WB)  assert (wb_valid && wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_rt);
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed pipeline scenarios plus randomized traffic against a reference model.
// Latency: stall/bubble checked before the edge, forward selects and counter one edge later.
// Backpressure: stalled ID instructions are held in the random run, as a real pipeline would.
module tb_fwd_hazard_ctrl;

    logic        clk, rst, id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, flush;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [1:0]  forwarda, forwardb;
    logic        stall, bubble;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    fwd_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .forwarda(forwarda), .forwardb(forwardb), .stall(stall), .bubble(bubble),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: in-flight instruction list, index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct packed {
        logic       valid;
        logic [4:0] rs, rt, rd;
        logic       regwrite, memread;
    } ins_t;

    ins_t        pipe [0:2];
    logic [1:0]  m_fa, m_fb;
    logic [15:0] m_cnt;

    task automatic m_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        m_fa  = 2'b00;
        m_fb  = 2'b00;
        m_cnt = 16'd0;
    endtask

    function automatic logic produces(input ins_t s, input logic [4:0] r);
        return s.valid && s.regwrite && s.rd != 5'd0 && s.rd == r;
    endfunction

    function automatic logic m_stall_f();
        ins_t e = pipe[0];
        if (!id_valid || flush || !e.valid || !e.memread || e.rd == 5'd0) return 1'b0;
        return (id_use_rs && id_rs == e.rd) || (id_use_rt && id_rt == e.rd);
    endfunction

    // Youngest in-flight producer ahead of ID; a load in EX has no data yet and is skipped.
    function automatic logic [1:0] m_sel(input logic [4:0] r, input logic use_r);
        if (!use_r) return 2'b00;
        for (int d = 0; d < 2; d++) begin
            if (produces(pipe[d], r) && !(d == 0 && pipe[d].memread))
                return (d == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    task automatic tick();
        logic st, bub;
        st  = m_stall_f();
        bub = st | flush;
        m_fa = bub ? 2'b00 : m_sel(id_rs, id_use_rs);
        m_fb = bub ? 2'b00 : m_sel(id_rt, id_use_rt);
        if (st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = '{valid: id_valid & ~bub, rs: id_rs, rt: id_rt, rd: id_rd,
                    regwrite: id_regwrite & ~bub, memread: id_memread & ~bub};
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic fl);
        id_valid = v;  id_rs = rs;  id_rt = rt;  id_use_rs = urs;  id_use_rt = urt;
        id_rd = rd;  id_regwrite = rw;  id_memread = mr;  flush = fl;
        #1;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        drive(1'b1, rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic lw(input logic [4:0] rd, input logic [4:0] rs);
        drive(1'b1, rs, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        alu(5'd3, 5'd1, 5'd2);
        repeat (2) @(posedge clk);
        #1;
        total++; if (forwarda !== 2'b00) begin bad++; $display("FAIL reset_fwda got=%b want=00", forwarda); end
        total++; if (forwardb !== 2'b00) begin bad++; $display("FAIL reset_fwdb got=%b want=00", forwardb); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        total++; if (bubble !== 1'b0) begin bad++; $display("FAIL reset_bubble got=%b want=0", bubble); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", stall_cnt); end
        rst = 1'b0;
        m_reset();
        nop();
        tick();
    endtask

    task automatic test_back_to_back();
        alu(5'd3, 5'd1, 5'd2);  tick();
        alu(5'd5, 5'd3, 5'd4);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%b want=0", stall); end
        tick();
        nop();
        total++; if (forwarda !== 2'b10) begin bad++; $display("FAIL b2b_fwda got=%b want=10", forwarda); end
        total++; if (forwardb !== 2'b00) begin bad++; $display("FAIL b2b_fwdb got=%b want=00", forwardb); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_ex_stall got=%b want=0", stall); end
    endtask

    task automatic test_distance_two();
        alu(5'd3, 5'd1, 5'd2);  tick();
        nop();                  tick();
        alu(5'd6, 5'd1, 5'd3);  tick();
        nop();
        total++; if (forwardb !== 2'b01) begin bad++; $display("FAIL dist2_fwdb got=%b want=01", forwardb); end
        total++; if (forwarda !== 2'b00) begin bad++; $display("FAIL dist2_fwda got=%b want=00", forwarda); end
        tick();
    endtask

    task automatic test_load_use();
        lw(5'd2, 5'd1);  tick();
        alu(5'd4, 5'd2, 5'd2);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b want=1", stall); end
        total++; if (bubble !== 1'b1) begin bad++; $display("FAIL lu_bubble got=%b want=1", bubble); end
        tick();
        alu(5'd4, 5'd2, 5'd2);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall_once got=%b want=0", stall); end
        total++; if (bubble !== 1'b0) begin bad++; $display("FAIL lu_bubble_once got=%b want=0", bubble); end
        total++; if (forwarda !== 2'b00) begin bad++; $display("FAIL lu_bubble_fwda got=%b want=00", forwarda); end
        total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d want=1", stall_cnt); end
        tick();
        nop();
        total++; if (forwarda !== 2'b01) begin bad++; $display("FAIL lu_fwda got=%b want=01", forwarda); end
        total++; if (forwardb !== 2'b01) begin bad++; $display("FAIL lu_fwdb got=%b want=01", forwardb); end
        tick();
    endtask

    task automatic test_double_producer();
        alu(5'd3, 5'd1, 5'd2);  tick();
        alu(5'd3, 5'd4, 5'd5);  tick();
        alu(5'd7, 5'd3, 5'd3);  tick();
        total++; if (forwarda !== 2'b10) begin bad++; $display("FAIL dbl_fwda got=%b want=10", forwarda); end
        total++; if (forwardb !== 2'b10) begin bad++; $display("FAIL dbl_fwdb got=%b want=10", forwardb); end
        alu(5'd0, 5'd1, 5'd2);  tick();
        alu(5'd8, 5'd0, 5'd0);  tick();
        total++; if (forwarda !== 2'b00) begin bad++; $display("FAIL r0_fwda got=%b want=00", forwarda); end
        total++; if (forwardb !== 2'b00) begin bad++; $display("FAIL r0_fwdb got=%b want=00", forwardb); end
        lw(5'd0, 5'd1);  tick();
        alu(5'd9, 5'd0, 5'd0);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL r0_load_stall got=%b want=0", stall); end
        tick();
        nop();
        total++; if (forwarda !== 2'b00) begin bad++; $display("FAIL r0_load_fwda got=%b want=00", forwarda); end
        tick();
    endtask

    task automatic test_flush();
        logic [15:0] cnt_before;
        lw(5'd2, 5'd1);  tick();
        cnt_before = m_cnt;
        drive(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b want=0", stall); end
        total++; if (bubble !== 1'b1) begin bad++; $display("FAIL flush_bubble got=%b want=1", bubble); end
        tick();
        nop();
        total++; if (stall_cnt !== cnt_before) begin bad++; $display("FAIL flush_cnt got=%0d want=%0d", stall_cnt, cnt_before); end
        total++; if (forwarda !== 2'b00) begin bad++; $display("FAIL flush_fwda got=%b want=00", forwarda); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        alu(5'd7, 5'd1, 5'd2);  tick();
        lw(5'd2, 5'd7);         tick();
        alu(5'd4, 5'd2, 5'd2);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL rms_pre_stall got=%b want=1", stall); end
        total++; if (forwarda !== 2'b10) begin bad++; $display("FAIL rms_pre_fwda got=%b want=10", forwarda); end
        rst = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rms_stall got=%b want=0", stall); end
        total++; if (bubble !== 1'b0) begin bad++; $display("FAIL rms_bubble got=%b want=0", bubble); end
        total++; if (forwarda !== 2'b00) begin bad++; $display("FAIL rms_fwda got=%b want=00", forwarda); end
        total++; if (forwardb !== 2'b00) begin bad++; $display("FAIL rms_fwdb got=%b want=00", forwardb); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rms_cnt got=%0d want=0", stall_cnt); end
        rst = 1'b0;
        m_reset();
        #1;
        tick();
        nop();
        total++; if (forwarda !== 2'b00) begin bad++; $display("FAIL rms_after_fwda got=%b want=00", forwarda); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rms_after_cnt got=%0d want=0", stall_cnt); end
        tick();
    endtask

    task automatic test_random();
        logic e_st, e_bub, held;
        held = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!held) begin
                id_valid    = ($urandom_range(0, 99) < 85);
                id_rs       = 5'($urandom_range(0, 7));
                id_rt       = 5'($urandom_range(0, 7));
                id_use_rs   = ($urandom_range(0, 99) < 80);
                id_use_rt   = ($urandom_range(0, 99) < 60);
                id_rd       = 5'($urandom_range(0, 7));
                id_regwrite = ($urandom_range(0, 99) < 75);
                id_memread  = id_regwrite && ($urandom_range(0, 99) < 35);
            end
            flush = ($urandom_range(0, 99) < 10);
            #1;
            e_st  = m_stall_f();
            e_bub = e_st | flush;
            total++; if (stall !== e_st) begin bad++; $display("FAIL rand_stall cyc=%0d got=%b want=%b", i, stall, e_st); end
            total++; if (bubble !== e_bub) begin bad++; $display("FAIL rand_bubble cyc=%0d got=%b want=%b", i, bubble, e_bub); end
            tick();
            total++; if (forwarda !== m_fa) begin bad++; $display("FAIL rand_fwda cyc=%0d got=%b want=%b", i, forwarda, m_fa); end
            total++; if (forwardb !== m_fb) begin bad++; $display("FAIL rand_fwdb cyc=%0d got=%b want=%b", i, forwardb, m_fb); end
            total++; if (stall_cnt !== m_cnt) begin bad++; $display("FAIL rand_cnt cyc=%0d got=%0d want=%0d", i, stall_cnt, m_cnt); end
            held = e_st;
        end
        nop();
        tick();
    endtask

    task automatic test_saturation();
        int  n;
        logic st;
        n = 0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        m_reset();
        lw(5'd2, 5'd2);
        for (int i = 0; i < 140000 && n < 65540; i++) begin
            st = m_stall_f();
            if (st) n++;
            tick();
            if (st && n == 65534) begin
                total++; if (stall_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_fffe got=%h want=fffe", stall_cnt); end
            end
            if (st && n == 65535) begin
                total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_ffff got=%h want=ffff", stall_cnt); end
            end
        end
        total++; if (n != 65540) begin bad++; $display("FAIL sat_budget stalls=%0d want=65540", n); end
        total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h want=ffff", stall_cnt); end
        nop();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 1'b0;  id_rs = 5'd0;  id_rt = 5'd0;  id_use_rs = 1'b0;  id_use_rt = 1'b0;
        id_rd = 5'd0;  id_regwrite = 1'b0;  id_memread = 1'b0;  flush = 1'b0;
        m_reset();
        test_reset();
        test_back_to_back();
        test_distance_two();
        test_load_use();
        test_double_producer();
        test_flush();
        test_reset_mid_stall();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
